// File: rtl/stepper_phase_monitor_pkg.sv
// Shared definitions for the stepper phase monitor: coil one-hot patterns and FSM states.
package stepper_phase_monitor_pkg;

  // Coil patterns in driver dir0 order; phase index equals position in this sequence.
  localparam logic [3:0] CoilPh0 = 4'b0001;
  localparam logic [3:0] CoilPh1 = 4'b1000;
  localparam logic [3:0] CoilPh2 = 4'b0100;
  localparam logic [3:0] CoilPh3 = 4'b0010;
  localparam logic [3:0] CoilOff = 4'b0000;

  localparam logic [7:0] RevMax = 8'hFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StFault = 2'd2
  } state_e;

endpackage

// File: rtl/stepper_phase_decode.sv
// Combinational coil pattern decoder: phase index, legal one-hot flag and de-energised flag.
module stepper_phase_decode
  import stepper_phase_monitor_pkg::*;
(
  input  logic [3:0] coil_i,
  output logic [1:0] idx_o,
  output logic       valid_o,
  output logic       off_o
);

  always_comb begin
    idx_o   = 2'd0;
    valid_o = 1'b1;
    off_o   = 1'b0;
    case (coil_i)
      CoilPh0: idx_o = 2'd0;
      CoilPh1: idx_o = 2'd1;
      CoilPh2: idx_o = 2'd2;
      CoilPh3: idx_o = 2'd3;
      CoilOff: begin
        valid_o = 1'b0;
        off_o   = 1'b1;
      end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/stepper_phase_monitor.sv
// Receive-side monitor for the stepper driver coil pattern: decodes steps, direction, position,
// revolutions, and flags skipped phases, illegal patterns and stalls.
module stepper_phase_monitor
  import stepper_phase_monitor_pkg::*;
#(
  parameter int unsigned PosW        = 16,
  parameter int unsigned StepsPerRev = 2048,
  parameter int unsigned StallCyc    = 2097152,
  parameter int unsigned StallW      = 22
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic [3:0]      coil_i,
  output logic            step_pulse_o,
  output logic            step_dir_o,
  output logic [PosW-1:0] position_o,
  output logic            rev_done_o,
  output logic [7:0]      rev_count_o,
  output logic            moving_o,
  output logic            stalled_o,
  output logic            err_skip_o,
  output logic            err_illegal_o
);

  localparam int unsigned IdxW = (StepsPerRev > 1) ? $clog2(StepsPerRev) : 1;
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(StepsPerRev - 1);
  localparam logic [StallW-1:0] StallMax = StallW'(StallCyc);

  state_e            state_q, state_d;
  logic [3:0]        coil_q;
  logic [1:0]        phase_q, phase_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        rev_q, rev_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              dir_q, dir_d;
  logic              pulse_q, pulse_d;
  logic              rev_done_q, rev_done_d;
  logic              err_skip_q, err_skip_d;
  logic              err_ill_q, err_ill_d;

  logic [1:0] dec_idx;
  logic       dec_valid;
  logic       dec_off;
  logic [1:0] phase_diff;
  logic       stall_hit;

  stepper_phase_decode u_decode (
    .coil_i  (coil_q),
    .idx_o   (dec_idx),
    .valid_o (dec_valid),
    .off_o   (dec_off)
  );

  assign phase_diff = dec_idx - phase_q;
  assign stall_hit  = (stall_q == StallMax);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    rev_d      = rev_q;
    stall_d    = stall_q;
    dir_d      = dir_q;
    pulse_d    = 1'b0;
    rev_done_d = 1'b0;
    err_skip_d = err_skip_q;
    err_ill_d  = err_ill_q;

    if (clr_i) begin
      // Clear wins over any step decoded in the same cycle.
      state_d    = StIdle;
      pos_d      = '0;
      idx_d      = '0;
      rev_d      = '0;
      stall_d    = '0;
      dir_d      = 1'b0;
      err_skip_d = 1'b0;
      err_ill_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dec_valid) begin
            phase_d = dec_idx;
            stall_d = '0;
            state_d = StTrack;
          end else if (!dec_off) begin
            err_ill_d = 1'b1;
            state_d   = StFault;
          end
        end
        StTrack: begin
          if (dec_off) begin
            stall_d = '0;
            state_d = StIdle;
          end else if (!dec_valid) begin
            err_ill_d = 1'b1;
            state_d   = StFault;
          end else begin
            case (phase_diff)
              2'd0: if (!stall_hit) stall_d = stall_q + StallW'(1);
              2'd1: begin
                phase_d = dec_idx;
                pos_d   = pos_q + PosW'(1);
                dir_d   = 1'b0;
                pulse_d = 1'b1;
                stall_d = '0;
                if (idx_q == IdxLast) begin
                  idx_d      = '0;
                  rev_done_d = 1'b1;
                  if (rev_q != RevMax) rev_d = rev_q + 8'd1;
                end else begin
                  idx_d = idx_q + IdxW'(1);
                end
              end
              2'd3: begin
                phase_d = dec_idx;
                pos_d   = pos_q - PosW'(1);
                dir_d   = 1'b1;
                pulse_d = 1'b1;
                stall_d = '0;
                if (idx_q == '0) begin
                  idx_d = IdxLast;
                  if (rev_q != 8'd0) rev_d = rev_q - 8'd1;
                end else begin
                  idx_d = idx_q - IdxW'(1);
                end
              end
              default: begin
                phase_d    = dec_idx;
                err_skip_d = 1'b1;
                stall_d    = '0;
              end
            endcase
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      coil_q     <= '0;
      phase_q    <= '0;
      pos_q      <= '0;
      idx_q      <= '0;
      rev_q      <= '0;
      stall_q    <= '0;
      dir_q      <= 1'b0;
      pulse_q    <= 1'b0;
      rev_done_q <= 1'b0;
      err_skip_q <= 1'b0;
      err_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      coil_q     <= coil_i;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      idx_q      <= idx_d;
      rev_q      <= rev_d;
      stall_q    <= stall_d;
      dir_q      <= dir_d;
      pulse_q    <= pulse_d;
      rev_done_q <= rev_done_d;
      err_skip_q <= err_skip_d;
      err_ill_q  <= err_ill_d;
    end
  end

  assign step_pulse_o  = pulse_q;
  assign step_dir_o    = dir_q;
  assign position_o    = pos_q;
  assign rev_done_o    = rev_done_q;
  assign rev_count_o   = rev_q;
  assign moving_o      = (state_q == StTrack) && !stall_hit;
  assign stalled_o     = (state_q == StTrack) && stall_hit;
  assign err_skip_o    = err_skip_q;
  assign err_illegal_o = err_ill_q;

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Directed bench for stepper_phase_monitor with a per-cycle expected-value scoreboard.
module tb_stepper_phase_monitor;

  localparam int SPR   = 8;
  localparam int STALL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  coil = 4'b0000;
  logic        step_pulse, step_dir, rev_done, moving, stalled, err_skip, err_illegal;
  logic [15:0] position;
  logic [7:0]  rev_count;

  stepper_phase_monitor #(
    .PosW        (16),
    .StepsPerRev (SPR),
    .StallCyc    (STALL),
    .StallW      (5)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clr_i         (clr),
    .coil_i        (coil),
    .step_pulse_o  (step_pulse),
    .step_dir_o    (step_dir),
    .position_o    (position),
    .rev_done_o    (rev_done),
    .rev_count_o   (rev_count),
    .moving_o      (moving),
    .stalled_o     (stalled),
    .err_skip_o    (err_skip),
    .err_illegal_o (err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pulse;
    logic        dir;
    logic [15:0] pos;
    logic        rd;
    logic [7:0]  rev;
    logic        mov;
    logic        stl;
    logic        skip;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   revs     = 0;

  // Reference model state (0 idle, 1 track, 2 fault)
  logic [3:0] m_coil_q;
  int m_st, m_ph, m_pos, m_idx, m_rev, m_timer;
  logic m_dir, m_pulse, m_rd, m_skip, m_ill;

  function automatic int ph_of(logic [3:0] c);
    case (c)
      4'b0001: return 0;
      4'b1000: return 1;
      4'b0100: return 2;
      4'b0010: return 3;
      4'b0000: return -1;
      default: return -2;
    endcase
  endfunction

  task automatic model_reset();
    m_coil_q = 4'b0000;
    m_st = 0; m_ph = 0; m_pos = 0; m_idx = 0; m_rev = 0; m_timer = 0;
    m_dir = 0; m_pulse = 0; m_rd = 0; m_skip = 0; m_ill = 0;
  endtask

  task automatic model_edge();
    int p, d;
    p = ph_of(m_coil_q);
    m_pulse = 0;
    m_rd = 0;
    if (clr) begin
      m_st = 0; m_pos = 0; m_idx = 0; m_rev = 0; m_timer = 0;
      m_dir = 0; m_skip = 0; m_ill = 0;
    end else if (m_st == 0) begin
      if (p >= 0) begin
        m_ph = p; m_st = 1; m_timer = 0;
      end else if (p == -2) begin
        m_ill = 1; m_st = 2;
      end
    end else if (m_st == 1) begin
      if (p == -1) begin
        m_st = 0; m_timer = 0;
      end else if (p == -2) begin
        m_ill = 1; m_st = 2;
      end else begin
        d = (p - m_ph + 4) % 4;
        if (d == 0) begin
          if (m_timer < STALL) m_timer++;
        end else if (d == 1) begin
          m_pos++; m_dir = 0; m_pulse = 1; m_timer = 0; m_ph = p;
          if (m_idx == SPR - 1) begin
            m_idx = 0; m_rd = 1;
            if (m_rev < 255) m_rev++;
          end else m_idx++;
        end else if (d == 3) begin
          m_pos--; m_dir = 1; m_pulse = 1; m_timer = 0; m_ph = p;
          if (m_idx == 0) begin
            m_idx = SPR - 1;
            if (m_rev > 0) m_rev--;
          end else m_idx--;
        end else begin
          m_skip = 1; m_ph = p; m_timer = 0;
        end
      end
    end
    m_coil_q = coil;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pulse = m_pulse;
    e.dir   = m_dir;
    e.pos   = 16'(m_pos);
    e.rd    = m_rd;
    e.rev   = 8'(m_rev);
    e.mov   = (m_st == 1) && (m_timer < STALL);
    e.stl   = (m_st == 1) && (m_timer >= STALL);
    e.skip  = m_skip;
    e.ill   = m_ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("step_pulse", 32'(step_pulse), 32'(e.pulse));
    chk("step_dir", 32'(step_dir), 32'(e.dir));
    chk("position", 32'(position), 32'(e.pos));
    chk("rev_done", 32'(rev_done), 32'(e.rd));
    chk("rev_count", 32'(rev_count), 32'(e.rev));
    chk("moving", 32'(moving), 32'(e.mov));
    chk("stalled", 32'(stalled), 32'(e.stl));
    chk("err_skip", 32'(err_skip), 32'(e.skip));
    chk("err_illegal", 32'(err_illegal), 32'(e.ill));
  endtask

  // One clock: model predicts at the edge, DUT outputs are checked on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    @(negedge clk);
    e = exp_q.pop_front();
    compare_all(e);
    if (step_pulse === 1'b1) pulses++;
    if (rev_done === 1'b1) revs++;
  endtask

  task automatic hold(input logic [3:0] c, input int n);
    coil = c;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] seq0 [4];
  int         cur;

  task automatic steps(input int n, input bit back);
    for (int i = 0; i < n; i++) begin
      cur = back ? (cur + 3) % 4 : (cur + 1) % 4;
      hold(seq0[cur], 3);
    end
  endtask

  logic [15:0] saved_pos;

  initial begin
    seq0[0] = 4'b0001; seq0[1] = 4'b1000; seq0[2] = 4'b0100; seq0[3] = 4'b0010;
    model_reset();
    #12;
    compare_all(model_out());
    @(negedge clk);
    rst_n = 1'b1;

    // 1: five dir0 phases from idle
    hold(4'b0000, 2);
    pulses = 0;
    hold(4'b0001, 4); hold(4'b1000, 4); hold(4'b0100, 4); hold(4'b0010, 4); hold(4'b0001, 4);
    chk("t1_pulses", 32'(pulses), 32'd4);
    chk("t1_pos", 32'(position), 32'd4);
    chk("t1_dir", 32'(step_dir), 32'd0);

    // 2: back to zero in dir1
    pulses = 0;
    hold(4'b0010, 4); hold(4'b0100, 4); hold(4'b1000, 4); hold(4'b0001, 4);
    chk("t2_pulses", 32'(pulses), 32'd4);
    chk("t2_pos", 32'(position), 32'd0);
    chk("t2_dir", 32'(step_dir), 32'd1);

    // 3: revolution counting and saturation at zero
    cur = 0;
    revs = 0;
    steps(8, 1'b0);
    chk("t3_revdone", 32'(revs), 32'd1);
    chk("t3_rev_up", 32'(rev_count), 32'd1);
    steps(8, 1'b1);
    chk("t3_rev_down", 32'(rev_count), 32'd0);
    steps(8, 1'b1);
    chk("t3_rev_sat", 32'(rev_count), 32'd0);
    chk("t3_revdone_total", 32'(revs), 32'd1);

    // 4: skipped phase, then a legal dir0 step from the re-latched phase
    hold(4'b0001, 4);
    saved_pos = position;
    pulses = 0;
    hold(4'b0100, 4);
    chk("t4_skip", 32'(err_skip), 32'd1);
    chk("t4_nopulse", 32'(pulses), 32'd0);
    chk("t4_pos_hold", 32'(position), 32'(saved_pos));
    hold(4'b0010, 4);
    chk("t4_step", 32'(position), 32'(saved_pos + 16'd1));

    // 5: illegal pattern -> fault, then clear
    hold(4'b0011, 4);
    chk("t5_ill", 32'(err_illegal), 32'd1);
    saved_pos = position;
    hold(4'b0001, 4); hold(4'b1000, 4);
    chk("t5_frozen", 32'(position), 32'(saved_pos));
    clr = 1'b1;
    hold(4'b0000, 1);
    clr = 1'b0;
    hold(4'b0000, 2);
    chk("t5_clr_pos", 32'(position), 32'd0);
    chk("t5_clr_flags", 32'({err_skip, err_illegal, moving, stalled}), 32'd0);

    // 6: stall detection, recovery by a step, then asynchronous reset
    hold(4'b0001, 20);
    chk("t6_stalled", 32'(stalled), 32'd1);
    chk("t6_not_moving", 32'(moving), 32'd0);
    hold(4'b1000, 3);
    chk("t6_moving", 32'(moving), 32'd1);
    chk("t6_unstalled", 32'(stalled), 32'd0);
    hold(4'b0100, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_pos", 32'(position), 32'd0);
    chk("t6_rst_all", 32'({step_pulse, step_dir, rev_done, rev_count, moving, stalled,
                           err_skip, err_illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0100, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
